// File: rtl/data_status_pipe.sv
// Elastic PIPE_DEPTH-stage data/status pipe with valid/ready backpressure, bubble collapse,
// synchronous flush and an occupancy count. Define DATA_STATUS_PIPE_PARITY_EN to add parity.
module data_status_pipe #(
    parameter int DATA_W     = 32,
    parameter int STATUS_W   = 1,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [STATUS_W-1:0] status_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   data_o,
    output logic [STATUS_W-1:0] status_o,
    input  logic                flush_i,
`ifdef DATA_STATUS_PIPE_PARITY_EN
    input  logic                parity_inject_i,
    output logic                parity_err_o,
`endif
    output logic [PIPE_DEPTH-1:0] stage_valid_o,
    output logic [DATA_W-1:0]     stage_data_o   [PIPE_DEPTH],
    output logic [STATUS_W-1:0]   stage_status_o [PIPE_DEPTH],
    output logic [CNT_W-1:0]      occupancy_o
);

    logic [PIPE_DEPTH-1:0] r_valid;
    logic [DATA_W-1:0]     r_data   [PIPE_DEPTH];
    logic [STATUS_W-1:0]   r_status [PIPE_DEPTH];
    logic [CNT_W-1:0]      r_occ;
    logic [CNT_W-1:0]      w_occ_d;
    logic [PIPE_DEPTH-1:0] w_ready;
    logic                  w_tail_full;
    logic                  w_accept;
    logic                  w_xfer;

    // ready[k] = !valid[k] || ready[k+1], unrolled as "some stage from k to the end is empty"
    always_comb begin
        w_ready     = '0;
        w_tail_full = 1'b1;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            w_tail_full = w_tail_full & r_valid[k];
            w_ready[k]  = !w_tail_full || out_ready_i;
        end
    end

    assign in_ready_o = w_ready[0] && !flush_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_xfer     = r_valid[PIPE_DEPTH-1] && out_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_status[k] <= '0;
            end
        end else if (flush_i) begin
            r_valid <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_status[k] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0]  <= w_accept;
                r_status[0] <= w_accept ? status_i : '0;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (w_ready[k]) begin
                    r_valid[k]  <= r_valid[k-1];
                    r_status[k] <= r_valid[k-1] ? r_status[k-1] : '0;
                end
            end
        end
    end

    // Data carries no reset; it is only meaningful alongside its valid flag.
    always_ff @(posedge clk) begin
        if (w_ready[0]) begin
            r_data[0] <= data_i;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (w_ready[k]) begin
                r_data[k] <= r_data[k-1];
            end
        end
    end

    always_comb begin
        w_occ_d = r_occ;
        if (flush_i) begin
            w_occ_d = '0;
        end else if (w_accept && !w_xfer) begin
            w_occ_d = r_occ + 1'b1;
        end else if (!w_accept && w_xfer) begin
            w_occ_d = r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_d;
        end
    end

`ifdef DATA_STATUS_PIPE_PARITY_EN
    logic r_par [PIPE_DEPTH];
    logic r_parity_err;
    logic w_par_in;

    assign w_par_in = (^{data_i, status_i}) ^ parity_inject_i;

    always_ff @(posedge clk) begin
        if (w_ready[0]) begin
            r_par[0] <= w_par_in;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (w_ready[k]) begin
                r_par[k] <= r_par[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_xfer && ((^{data_o, status_o}) != r_par[PIPE_DEPTH-1]);
        end
    end

    assign parity_err_o = r_parity_err;
`endif

    assign out_valid_o    = r_valid[PIPE_DEPTH-1];
    assign data_o         = r_data[PIPE_DEPTH-1];
    assign status_o       = r_status[PIPE_DEPTH-1];
    assign stage_valid_o  = r_valid;
    assign stage_data_o   = r_data;
    assign stage_status_o = r_status;
    assign occupancy_o    = r_occ;

endmodule
